bot_upd_responder: RTL

- Hardware responder for the Rojobot update-interrupt handshake, acting as the acknowledging end of the update flag.
- Watches the latched bot-update request level and snapshots the 32-bit BotInfo word {LocX, LocY, Sensors, BotInfo} into a small FIFO.
- Returns the acknowledge pulse that clears the request latch.
- Lets firmware drain buffered snapshots at its own pace, so no update is lost while the CPU is busy.

---
 rtl/bot_upd_responder.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/bot_upd_responder.sv
// ---------------------------------------------------------------------------
// bot_upd_responder
//
// This module is the acknowledging end of the Rojobot update-interrupt
// handshake. It watches the latched bot-update request level. Once the
// BotInfo word has had time to settle, it snapshots the word into a small
// FIFO. It then holds an acknowledge to the request latch until the request
// drops. Firmware drains the FIFO at its own pace, so an update is not lost
// while the CPU is busy. When the FIFO is full, further snapshots are
// dropped and counted.
//
// Parameters:
//   DEPTH          FIFO entries. Must be a power of two and at least 2.
//   SETTLE_CYCLES  Clock cycles to wait after the request is seen before
//                  i_bot_info is sampled. 0 means no wait. Maximum is 15.
//
// Ports:
//   clk        system clock; all logic runs on the rising edge
//   rstn       asynchronous active-low reset
//   i_upd_req  latched bot-update request level; high until acknowledged
//   o_int_ack  registered acknowledge to the request latch
//   i_bot_info BotInfo word {LocX, LocY, Sensors, BotInfo}
//   i_rd_en    pop strobe from the CPU register interface
//   o_rd_data  FIFO head word (first-word-fall-through)
//   o_empty    FIFO empty
//   o_full     FIFO full
//   o_count    number of entries held
//   o_ovf_cnt  dropped-snapshot count; saturates at 255
//   i_clr_ovf  synchronous clear of o_ovf_cnt
//   o_irq      registered; high while the FIFO holds data
// ---------------------------------------------------------------------------
module bot_upd_responder #(
    parameter int DEPTH         = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_upd_req,
    output logic                     o_int_ack,
    input  logic [31:0]              i_bot_info,
    input  logic                     i_rd_en,
    output logic [31:0]              o_rd_data,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [7:0]               o_ovf_cnt,
    input  logic                     i_clr_ovf,
    output logic                     o_irq
);

    localparam int AW = $clog2(DEPTH);

    // The settle counter counts down to zero. It therefore starts at one
    // less than the wait length.
    localparam logic [3:0] SETTLE_LOAD = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;
    localparam logic [AW:0] PTR_ONE    = (AW + 1)'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        ACK     = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [3:0]     settle_q, settle_d;
    logic           ack_q;

    logic [AW:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]    rd_ptr_q, rd_ptr_d;
    logic [31:0]    mem_q [DEPTH];
    logic [7:0]     ovf_q, ovf_d;
    logic           irq_q;

    logic           empty;
    logic           full;
    logic           pop;
    logic           push;
    logic           drop;

    // -----------------------------------------------------------------------
    // FIFO status. The pointers carry one extra wrap bit. Equal pointers mean
    // the FIFO is empty. Equal low bits with different wrap bits mean it is
    // full.
    // -----------------------------------------------------------------------
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop while empty is ignored. This keeps the read pointer from ever
    // passing the write pointer.
    assign pop   = i_rd_en && !empty;

    // -----------------------------------------------------------------------
    // Handshake FSM, next-state and capture decisions.
    // A drop in SETTLE is treated as a glitch and abandons the request.
    // In ACK the FSM waits for the request to fall, so a request that stays
    // high is captured only once.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        push     = 1'b0;
        drop     = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_upd_req) begin
                    if (SETTLE_CYCLES == 0) begin
                        state_d = CAPTURE;
                    end else begin
                        state_d  = SETTLE;
                        settle_d = SETTLE_LOAD;
                    end
                end
            end

            SETTLE: begin
                if (!i_upd_req) begin
                    state_d = IDLE;
                end else if (settle_q == 4'd0) begin
                    state_d = CAPTURE;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end

            CAPTURE: begin
                state_d = ACK;
                // A pop in this same cycle frees the head slot, so a full
                // FIFO can still accept the new word.
                if (!full || pop) begin
                    push = 1'b1;
                end else begin
                    drop = 1'b1;
                end
            end

            ACK: begin
                if (!i_upd_req) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Pointer and overflow-counter next state.
    // -----------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        // A clear takes priority over an increment in the same cycle.
        if (i_clr_ovf) begin
            ovf_d = 8'd0;
        end else if (drop && (ovf_q != 8'hFF)) begin
            ovf_d = ovf_q + 8'd1;
        end
    end

    // -----------------------------------------------------------------------
    // FSM, acknowledge and status registers.
    // The acknowledge and the interrupt are computed from next-state values.
    // Both therefore change on the same edge as the state or FIFO change
    // that causes them.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            settle_q <= 4'd0;
            ack_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 8'd0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            ack_q    <= (state_d == ACK);
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            irq_q    <= (wr_ptr_d != rd_ptr_d);
        end
    end

    // -----------------------------------------------------------------------
    // FIFO storage. It is cleared on reset so that the head reads 0 after
    // reset.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_bot_info;
        end
    end

    assign o_int_ack = ack_q;
    assign o_rd_data = mem_q[rd_ptr_q[AW-1:0]];
    assign o_empty   = empty;
    assign o_full    = full;
    assign o_count   = wr_ptr_q - rd_ptr_q;
    assign o_ovf_cnt = ovf_q;
    assign o_irq     = irq_q;

endmodule
